regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the pipeline's ID stage; successor to the single-write, 2-read register file.
- Configurable data and address width and read/write port counts.
- Clock-edge writes with priority resolution between write ports, optional write-to-read bypass, optional hardwired zero register.
- Sequenced post-reset clear, so no entry is ever X.

Parameters:
- DATA_W, 32, width of each register.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of read ports (>=1).
- NUM_WR, 1, number of write ports (>=1).
- ZERO_REG, 1, 1: entry 0 reads 0 and ignores writes; 0: entry 0 is ordinary.
- BYPASS, 1, 1: same-cycle write data forwarded to matching reads; 0: reads return stored value.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- raddr_i  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- rdata_o  out  NUM_RD*DATA_W  read data, combinational; port k at [k*DATA_W +: DATA_W].
- we_i  in  NUM_WR  write enable per port.
- waddr_i  in  NUM_WR*ADDR_W  write addresses, packed as raddr_i.
- wdata_i  in  NUM_WR*DATA_W  write data, packed as rdata_o.
- busy_o  out  1  high while the clear sequence runs; writes are ignored while high.
- wr_conflict_o  out  1  registered one-cycle pulse: two or more enabled write ports hit the same effective address in the previous cycle.

Behaviour:
- State machine: CLEAR and RUN.
  - rst_i=1 at a rising edge: state<=CLEAR, clr_ptr<=0, wr_conflict_o<=0. Takes priority over everything else.
  - In CLEAR, each edge writes 0 to entry clr_ptr, then clr_ptr<=clr_ptr+1.
  - When clr_ptr==DEPTH-1, that entry is cleared and state<=RUN.
  - CLEAR therefore lasts exactly DEPTH cycles after the reset edge.
- busy_o = (state==CLEAR), combinational from state.
  - Value after a reset edge: busy_o=1, wr_conflict_o=0.
  - busy_o falls at the edge that clears entry DEPTH-1.
- rst_i asserted mid-CLEAR: clr_ptr restarts at 0; full DEPTH cycles again.
- Reads during CLEAR: rdata_o = 0 on all ports, regardless of stored contents.
- Writes in RUN:
  - At the rising edge, for each port j with we_i[j]=1, entry waddr_j <= wdata_j.
  - Several enabled ports with the same address: highest-index port wins.
  - Write latency: value is visible on a non-bypassed read in the cycle after the edge.
- Writes while busy_o=1 are dropped silently; no conflict is flagged.
- ZERO_REG=1:
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0.
  - Address-0 collisions never set wr_conflict_o.
- Reads in RUN, combinational:
  - BYPASS=1: if any enabled write port targets raddr_k this cycle (excluding address 0 when ZERO_REG=1), rdata_k = wdata of the highest-index such port. Otherwise rdata_k = stored entry.
  - BYPASS=0: rdata_k = stored entry (pre-edge value).
- wr_conflict_o <= 1 at an edge in RUN if at least two enabled write ports share a non-discarded address; otherwise <=0.
- Read ports are fully independent; any number may read the same address.
- No internal storage may be X after CLEAR completes.

Test Plan:
1. Reset clear: pulse rst_i 1 cycle, DEPTH=32 -> busy_o=1 for exactly 32 cycles; all raddr 0..31 read 0x00000000 afterwards; wr_conflict_o=0 throughout.
2. Write/read latency, BYPASS=0: in RUN, we_i[0]=1, waddr=5, wdata=0xDEADBEEF, raddr_0=5 -> same cycle rdata_0 = old value (0); next cycle 0xDEADBEEF.
3. Bypass, BYPASS=1: same stimulus -> rdata_0=0xDEADBEEF in the write cycle. With NUM_WR=2, both ports write address 7 (0x11, 0x22) -> rdata=0x22 same cycle; entry 7=0x22 after; wr_conflict_o=1 for exactly the following cycle.
4. Zero register, ZERO_REG=1: write 0x12345678 to address 0 on two ports together -> reads of address 0 (bypass and stored) return 0; wr_conflict_o stays 0.
5. Reset mid-clear: assert rst_i again at clear cycle 10 -> busy_o stays high for 32 cycles after the second reset edge (42 total).
6. Write during busy: we_i=1, addr 3, data 0xA5A5A5A5 at clear cycle 2 -> after busy_o falls, entry 3 reads 0.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: read/write address, data and
// status signals grouped so the core and its user share one declaration.
//
// Handshake: there is no valid/ready pair. A read port is purely
// combinational (raddr_i in, rdata_o out in the same cycle). A write port
// commits at the rising edge when we_i[j] is high and busy_o is low; while
// busy_o is high every write is dropped and the master must simply retry.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    logic [NUM_RD*ADDR_W-1:0] raddr_i;
    logic [NUM_RD*DATA_W-1:0] rdata_o;
    logic [NUM_WR-1:0]        we_i;
    logic [NUM_WR*ADDR_W-1:0] waddr_i;
    logic [NUM_WR*DATA_W-1:0] wdata_i;
    logic                     busy_o;
    logic                     wr_conflict_o;
    // FSM state for observation: 0 = CLEAR, 1 = RUN
    logic [0:0]               dbg_state_o;

    modport master (
        output raddr_i, we_i, waddr_i, wdata_i,
        input  rdata_o, busy_o, wr_conflict_o, dbg_state_o
    );

    modport slave (
        input  raddr_i, we_i, waddr_i, wdata_i,
        output rdata_o, busy_o, wr_conflict_o, dbg_state_o
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file for the ID stage. Entries are zeroed by a
// sequenced walk after reset, writes resolve highest-port-wins, reads can
// optionally see same-cycle write data, and entry 0 can be hardwired to 0.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic                wr_conflict_q, wr_conflict_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    // Unpacked views of the flat bus vectors
    logic [ADDR_W-1:0]   raddr [NUM_RD];
    logic [ADDR_W-1:0]   waddr [NUM_WR];
    logic [DATA_W-1:0]   wdata [NUM_WR];
    logic [DATA_W-1:0]   rdata [NUM_RD];
    // A write that will actually land this edge (RUN, enabled, not entry 0 when hardwired)
    logic [NUM_WR-1:0]   wen_eff;
    logic                run;

    assign run = (state_q == ST_RUN);

    // Split the packed address/data buses into per-port values
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            raddr[k] = bus.raddr_i[k*ADDR_W +: ADDR_W];
        end
        for (int j = 0; j < NUM_WR; j++) begin
            waddr[j] = bus.waddr_i[j*ADDR_W +: ADDR_W];
            wdata[j] = bus.wdata_i[j*DATA_W +: DATA_W];
        end
    end

    // Qualify each write port: dropped while clearing and, if hardwired, at entry 0
    always_comb begin
        for (int j = 0; j < NUM_WR; j++) begin
            wen_eff[j] = bus.we_i[j] && run &&
                         !((ZERO_REG != 0) && (waddr[j] == '0));
        end
    end

    // Next-state logic: walk clr_ptr through every entry, then settle in RUN
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    // Collision detect: two landing writes to the same entry in this cycle
    always_comb begin
        wr_conflict_d = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (wen_eff[i] && wen_eff[j] && (waddr[i] == waddr[j])) begin
                    wr_conflict_d = 1'b1;
                end
            end
        end
    end

    // FSM, clear pointer and conflict flag registers; reset restarts the walk
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_CLEAR;
            clr_ptr_q     <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_ptr_q     <= clr_ptr_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // Storage: clear walk in CLEAR, port writes in RUN; later ports override earlier ones
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clr_ptr_q] <= '0;
            end else begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wen_eff[j]) begin
                        mem_q[waddr[j]] <= wdata[j];
                    end
                end
            end
        end
    end

    // Read ports: zero while clearing or for hardwired entry 0, else bypass or stored value
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rdata[k] = mem_q[raddr[k]];
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wen_eff[j] && (waddr[j] == raddr[k])) begin
                        rdata[k] = wdata[j];
                    end
                end
            end
            if (!run || ((ZERO_REG != 0) && (raddr[k] == '0))) begin
                rdata[k] = '0;
            end
        end
    end

    // Repack read data and drive status outputs
    always_comb begin
        bus.rdata_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            bus.rdata_o[k*DATA_W +: DATA_W] = rdata[k];
        end
    end

    assign bus.busy_o        = (state_q == ST_CLEAR);
    assign bus.wr_conflict_o = wr_conflict_q;
    assign bus.dbg_state_o   = state_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (bypass + zero register, and plain
// storage without zero register) share the same stimulus and are compared
// against a behavioural array model every cycle.
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int DEPTH = 32;

    logic clk;
    logic rst;
    logic          we [NW];
    logic [AW-1:0] wa [NW];
    logic [DW-1:0] wd [NW];
    logic [AW-1:0] ra [NR];

    int tests_run;
    int tests_failed;

    // Model state: dut index 0 = BYPASS=1/ZERO_REG=1, 1 = BYPASS=0/ZERO_REG=0
    logic [DW-1:0] mem_m [2][DEPTH];
    int            busy_rem;
    logic          conf_m [2];
    bit            byp [2] = '{1'b1, 1'b0};
    bit            zr  [2] = '{1'b1, 1'b0};

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) if_a ();
    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) if_b ();

    assign if_a.raddr_i = {ra[1], ra[0]};
    assign if_a.we_i    = {we[1], we[0]};
    assign if_a.waddr_i = {wa[1], wa[0]};
    assign if_a.wdata_i = {wd[1], wd[0]};
    assign if_b.raddr_i = {ra[1], ra[0]};
    assign if_b.we_i    = {we[1], we[0]};
    assign if_b.waddr_i = {wa[1], wa[0]};
    assign if_b.wdata_i = {wd[1], wd[0]};

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                 .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .bus(if_a)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                 .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .bus(if_b)
    );

    logic [DW-1:0] rd_obs [2][NR];
    logic          busy_obs [2];
    logic          conf_obs [2];
    assign rd_obs[0][0] = if_a.rdata_o[DW-1:0];
    assign rd_obs[0][1] = if_a.rdata_o[2*DW-1:DW];
    assign rd_obs[1][0] = if_b.rdata_o[DW-1:0];
    assign rd_obs[1][1] = if_b.rdata_o[2*DW-1:DW];
    assign busy_obs[0]  = if_a.busy_o;
    assign busy_obs[1]  = if_b.busy_o;
    assign conf_obs[0]  = if_a.wr_conflict_o;
    assign conf_obs[1]  = if_b.wr_conflict_o;

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Does write port j land in model d this cycle?
    function automatic bit lands(int d, int j);
        return we[j] && (busy_rem == 0) && !(zr[d] && (wa[j] == '0));
    endfunction

    function automatic logic [DW-1:0] exp_rd(int d, int k);
        logic [DW-1:0] r;
        if (busy_rem > 0) return '0;
        if (zr[d] && (ra[k] == '0)) return '0;
        r = mem_m[d][ra[k]];
        if (byp[d]) begin
            for (int j = 0; j < NW; j++) begin
                if (lands(d, j) && (wa[j] == ra[k])) r = wd[j];
            end
        end
        return r;
    endfunction

    // One clock: check outputs for the current inputs, then advance the model across the edge
    task automatic tick(input bit do_chk);
        #1;
        if (do_chk) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("busy_%0d", d), {31'b0, busy_obs[d]}, {31'b0, busy_rem > 0});
                chk($sformatf("conflict_%0d", d), {31'b0, conf_obs[d]}, {31'b0, conf_m[d]});
                for (int k = 0; k < NR; k++) begin
                    chk($sformatf("rdata_%0d_port%0d_addr%0d", d, k, ra[k]), rd_obs[d][k], exp_rd(d, k));
                end
            end
        end
        @(posedge clk);
        if (rst) begin
            busy_rem = DEPTH;
            for (int d = 0; d < 2; d++) begin
                conf_m[d] = 1'b0;
                for (int a = 0; a < DEPTH; a++) mem_m[d][a] = '0;
            end
        end else if (busy_rem > 0) begin
            busy_rem--;
            conf_m[0] = 1'b0;
            conf_m[1] = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                conf_m[d] = 1'b0;
                for (int i = 0; i < NW; i++)
                    for (int j = i + 1; j < NW; j++)
                        if (lands(d, i) && lands(d, j) && (wa[i] == wa[j])) conf_m[d] = 1'b1;
                for (int j = 0; j < NW; j++)
                    if (lands(d, j)) mem_m[d][wa[j]] = wd[j];
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        for (int j = 0; j < NW; j++) begin
            we[j] = 1'b0;
            wa[j] = '0;
            wd[j] = '0;
        end
    endtask

    task automatic rand_inputs(input int amax);
        for (int j = 0; j < NW; j++) begin
            we[j] = 1'($urandom_range(0, 1));
            wa[j] = AW'($urandom_range(0, amax));
            wd[j] = $urandom;
        end
        for (int k = 0; k < NR; k++) ra[k] = AW'($urandom_range(0, amax));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        busy_rem     = 0;
        conf_m[0]    = 1'b0;
        conf_m[1]    = 1'b0;
        rst          = 1'b1;
        idle_inputs();
        ra[0] = '0;
        ra[1] = '0;

        // Reset edge, then the full clear walk with junk writes that must be dropped
        tick(1'b0);
        rst = 1'b0;
        for (int c = 0; c < DEPTH; c++) begin
            rand_inputs(31);
            if (c == 2) begin
                we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'hA5A5_A5A5;
            end
            if (c == 5) begin
                we[0] = 1'b1; we[1] = 1'b1; wa[0] = 5'd9; wa[1] = 5'd9;
            end
            tick(1'b1);
        end

        // Every entry reads zero after the walk
        idle_inputs();
        for (int a = 0; a < DEPTH; a += 2) begin
            ra[0] = AW'(a);
            ra[1] = AW'(a + 1);
            tick(1'b1);
        end

        // Single write: bypass instance sees it now, plain instance next cycle
        ra[0] = 5'd5; ra[1] = 5'd3;
        we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hDEAD_BEEF;
        tick(1'b1);
        idle_inputs();
        tick(1'b1);

        // Two ports hit entry 7: port 1 wins, conflict pulses for one cycle
        ra[0] = 5'd7; ra[1] = 5'd7;
        we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'h0000_0011;
        we[1] = 1'b1; wa[1] = 5'd7; wd[1] = 32'h0000_0022;
        tick(1'b1);
        idle_inputs();
        tick(1'b1);
        tick(1'b1);

        // Both ports write entry 0
        ra[0] = 5'd0; ra[1] = 5'd0;
        we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'h1234_5678;
        we[1] = 1'b1; wa[1] = 5'd0; wd[1] = 32'h1234_5678;
        tick(1'b1);
        idle_inputs();
        tick(1'b1);
        tick(1'b1);

        // Random traffic over a narrow address range to provoke collisions
        for (int c = 0; c < 200; c++) begin
            rand_inputs(7);
            tick(1'b1);
        end
        for (int c = 0; c < 60; c++) begin
            rand_inputs(31);
            tick(1'b1);
        end

        // Reset from RUN, then again at clear cycle 10
        rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            rand_inputs(31);
            tick(1'b1);
        end
        rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        for (int c = 0; c < DEPTH; c++) begin
            rand_inputs(31);
            tick(1'b1);
        end

        // Contents after the restarted walk, then more random traffic
        idle_inputs();
        for (int a = 0; a < DEPTH; a += 2) begin
            ra[0] = AW'(a);
            ra[1] = AW'(a + 1);
            tick(1'b1);
        end
        for (int c = 0; c < 100; c++) begin
            rand_inputs(7);
            tick(1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
